// File: rtl/clock_pkg.sv
// Shared types and BCD helpers for the multi-channel time-of-day core.
package clock_pkg;

    localparam int unsigned BCD_W       = 4;
    localparam int unsigned MAX_HOUR    = 23;
    localparam int unsigned MAX_MIN_SEC = 59;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        SET_H = 2'd1,
        SET_M = 2'd2,
        SET_S = 2'd3
    } edit_state_e;

    typedef logic [BCD_W-1:0] bcd_t;

    typedef struct packed {
        bcd_t h10;
        bcd_t h1;
        bcd_t m10;
        bcd_t m1;
        bcd_t s10;
        bcd_t s1;
    } hms_t;

    function automatic logic [2*BCD_W-1:0] to_bcd2(input int unsigned n);
        return {BCD_W'(n / 10), BCD_W'(n % 10)};
    endfunction

    // Two-digit BCD increment that wraps to 00 after max_n.
    function automatic logic [2*BCD_W-1:0] bcd2_inc(input logic [2*BCD_W-1:0] v,
                                                    input int unsigned max_n);
        logic [2*BCD_W-1:0] r;
        if (v == to_bcd2(max_n)) begin
            r = '0;
        end else if (v[BCD_W-1:0] == BCD_W'(9)) begin
            r = {v[2*BCD_W-1:BCD_W] + BCD_W'(1), BCD_W'(0)};
        end else begin
            r = {v[2*BCD_W-1:BCD_W], v[BCD_W-1:0] + BCD_W'(1)};
        end
        return r;
    endfunction

endpackage

// File: rtl/hms_counter.sv
// One hh:mm:ss BCD channel: ticks with carry, or single-field edits without carry.
module hms_counter
    import clock_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic tick_en,
    input  logic inc_h,
    input  logic inc_m,
    input  logic inc_s,
    output hms_t hms,
    output logic wrap
);

    hms_t hms_q, hms_d;
    logic wrap_q, wrap_d;
    logic [2*BCD_W-1:0] hh, mm, ss;
    logic h_max, m_max, s_max;

    always_comb begin
        hh     = {hms_q.h10, hms_q.h1};
        mm     = {hms_q.m10, hms_q.m1};
        ss     = {hms_q.s10, hms_q.s1};
        h_max  = (hh == to_bcd2(MAX_HOUR));
        m_max  = (mm == to_bcd2(MAX_MIN_SEC));
        s_max  = (ss == to_bcd2(MAX_MIN_SEC));
        hms_d  = hms_q;
        wrap_d = 1'b0;
        if (inc_h) begin
            {hms_d.h10, hms_d.h1} = bcd2_inc(hh, MAX_HOUR);
        end else if (inc_m) begin
            {hms_d.m10, hms_d.m1} = bcd2_inc(mm, MAX_MIN_SEC);
        end else if (inc_s) begin
            {hms_d.s10, hms_d.s1} = bcd2_inc(ss, MAX_MIN_SEC);
        end else if (tick_en) begin
            {hms_d.s10, hms_d.s1} = bcd2_inc(ss, MAX_MIN_SEC);
            if (s_max) begin
                {hms_d.m10, hms_d.m1} = bcd2_inc(mm, MAX_MIN_SEC);
            end
            if (s_max && m_max) begin
                {hms_d.h10, hms_d.h1} = bcd2_inc(hh, MAX_HOUR);
            end
            wrap_d = s_max && m_max && h_max;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hms_q  <= '0;
            wrap_q <= 1'b0;
        end else begin
            hms_q  <= hms_d;
            wrap_q <= wrap_d;
        end
    end

    assign hms  = hms_q;
    assign wrap = wrap_q;

endmodule

// File: rtl/multi_clock_core.sv
// N-channel time-of-day core: shared 1 Hz divider, channel select, edit FSM and
// registered display outputs for the selected channel.
module multi_clock_core
    import clock_pkg::*;
#(
    parameter int unsigned NUM_CLK = 2,
    parameter int unsigned CLK_HZ  = 50_000_000,
    parameter int unsigned SEL_W   = (NUM_CLK > 1) ? $clog2(NUM_CLK) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               mode,
    input  logic               add,
    input  logic               nextP,
    output logic [SEL_W-1:0]   sel,
    output logic [23:0]        time_bcd,
    output logic               second,
    output logic               minute,
    output logic               hour,
    output logic               editing,
    output logic [NUM_CLK-1:0] day_wrap
);

    localparam int unsigned CNT_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;

    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SEL_W-1:0]   sel_q, sel_d;
    edit_state_e        state_q, state_d;
    logic               tick_c, editing_c;
    logic               edit_h, edit_m, edit_s;
    logic [NUM_CLK-1:0] chan_tick, chan_inc_h, chan_inc_m, chan_inc_s, wrap_vec;
    hms_t               hms_arr [NUM_CLK];
    hms_t               sel_hms;

    logic [SEL_W-1:0]   sel_out_q, sel_out_d;
    hms_t               time_q, time_d;
    logic               second_q, second_d, minute_q, minute_d, hour_q, hour_d;
    logic               editing_q, editing_d;
    logic [NUM_CLK-1:0] day_wrap_q, day_wrap_d;

    assign tick_c    = (cnt_q == CNT_W'(CLK_HZ - 1));
    assign editing_c = (state_q != RUN);

    // Divider, channel select and edit FSM; mode beats nextP beats add.
    always_comb begin
        cnt_d   = tick_c ? '0 : cnt_q + CNT_W'(1);
        sel_d   = sel_q;
        state_d = state_q;
        edit_h  = 1'b0;
        edit_m  = 1'b0;
        edit_s  = 1'b0;
        if (mode) begin
            sel_d   = (sel_q == SEL_W'(NUM_CLK - 1)) ? '0 : sel_q + SEL_W'(1);
            state_d = RUN;
        end else if (nextP) begin
            case (state_q)
                RUN:     state_d = SET_H;
                SET_H:   state_d = SET_M;
                SET_M:   state_d = SET_S;
                default: state_d = RUN;
            endcase
        end else if (add) begin
            edit_h = (state_q == SET_H);
            edit_m = (state_q == SET_M);
            edit_s = (state_q == SET_S);
        end
    end

    // The selected channel is frozen while being edited; its ticks are dropped.
    always_comb begin
        chan_tick  = '0;
        chan_inc_h = '0;
        chan_inc_m = '0;
        chan_inc_s = '0;
        for (int unsigned i = 0; i < NUM_CLK; i++) begin
            chan_tick[i]  = tick_c && !(editing_c && (SEL_W'(i) == sel_q));
            chan_inc_h[i] = edit_h && (SEL_W'(i) == sel_q);
            chan_inc_m[i] = edit_m && (SEL_W'(i) == sel_q);
            chan_inc_s[i] = edit_s && (SEL_W'(i) == sel_q);
        end
    end

    for (genvar g = 0; g < NUM_CLK; g++) begin : g_chan
        hms_counter u_hms (
            .clk     (clk),
            .rst     (rst),
            .tick_en (chan_tick[g]),
            .inc_h   (chan_inc_h[g]),
            .inc_m   (chan_inc_m[g]),
            .inc_s   (chan_inc_s[g]),
            .hms     (hms_arr[g]),
            .wrap    (wrap_vec[g])
        );
    end

    always_comb begin
        sel_hms = '0;
        for (int unsigned i = 0; i < NUM_CLK; i++) begin
            if (SEL_W'(i) == sel_q) begin
                sel_hms = hms_arr[i];
            end
        end
        sel_out_d  = sel_q;
        time_d     = sel_hms;
        editing_d  = editing_c;
        day_wrap_d = wrap_vec;
        second_d   = 1'b0;
        minute_d   = 1'b0;
        hour_d     = 1'b0;
        case (state_q)
            RUN:     second_d = sel_hms.s1[0];
            SET_H:   hour_d   = 1'b1;
            SET_M:   minute_d = 1'b1;
            default: second_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q      <= '0;
            sel_q      <= '0;
            state_q    <= RUN;
            sel_out_q  <= '0;
            time_q     <= '0;
            second_q   <= 1'b0;
            minute_q   <= 1'b0;
            hour_q     <= 1'b0;
            editing_q  <= 1'b0;
            day_wrap_q <= '0;
        end else begin
            cnt_q      <= cnt_d;
            sel_q      <= sel_d;
            state_q    <= state_d;
            sel_out_q  <= sel_out_d;
            time_q     <= time_d;
            second_q   <= second_d;
            minute_q   <= minute_d;
            hour_q     <= hour_d;
            editing_q  <= editing_d;
            day_wrap_q <= day_wrap_d;
        end
    end

    assign sel      = sel_out_q;
    assign time_bcd = time_q;
    assign second   = second_q;
    assign minute   = minute_q;
    assign hour     = hour_q;
    assign editing  = editing_q;
    assign day_wrap = day_wrap_q;

endmodule

// File: doc/multi_clock_core.md
# multi_clock_core

Parametrised N-channel time-of-day core that replaces the fixed two-clock arrangement in the clock top level. It holds NUM_CLK independent hh:mm:ss BCD counters driven by one shared 1 Hz tick. Synchronised button pulses select a channel and edit its fields. It presents the selected channel's time and indicator LEDs to the existing display serializer.

## Interface
Parameters:
- NUM_CLK, 2, number of independent clock channels (1..16).
- CLK_HZ, 50_000_000, input clock frequency; the divider period in cycles.
- SEL_W, $clog2(NUM_CLK) (minimum 1), width of the channel select.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- mode  in  1  one-cycle synchronised pulse; advance the selected channel.
- add  in  1  one-cycle synchronised pulse; increment the edited field.
- nextP  in  1  one-cycle synchronised pulse; advance the edit position.
- sel  out  SEL_W  currently selected channel (replaces modeDis).
- time_bcd  out  24  selected channel's time, packed {h10,h1,m10,m1,s10,s1}, 4 bits per digit.
- second  out  1  seconds LED.
- minute  out  1  minutes LED.
- hour  out  1  hours LED.
- editing  out  1  high while the edit FSM is not in RUN.
- day_wrap  out  NUM_CLK  one-cycle pulse per channel on the 23:59:59→00:00:00 wrap.

## Operation
- Divider:
  - Counts 0..CLK_HZ-1.
  - tick is high for one cycle when the count is CLK_HZ-1; the count then wraps to 0.
  - The divider is shared by all channels and never restarts except on rst.
- Channel counters:
  - On tick, each channel increments seconds; 59→00 carries into minutes; 59→00 carries into hours; 23→00.
  - Digits are always valid BCD.
  - Exception: the selected channel does not advance while editing is high (frozen). Ticks during editing are dropped, not accumulated.
- Edit FSM (acts on the selected channel only), states RUN, SET_H, SET_M, SET_S:
  - nextP moves RUN→SET_H→SET_M→SET_S→RUN.
  - add in SET_H increments hours mod 24, with no carry.
  - add in SET_M increments minutes mod 60, with no carry.
  - add in SET_S increments seconds mod 60, with no carry.
  - add in RUN is ignored.
- mode:
  - sel ← (sel+1) mod NUM_CLK.
  - The FSM is forced to RUN; edits already applied are kept.
- Simultaneous inputs:
  - mode with nextP or add: mode wins; the others are ignored that cycle.
  - nextP with add: nextP wins; add is ignored.
- LEDs:
  - RUN: second = selected channel s1[0]; minute = 0; hour = 0.
  - SET_H: only hour = 1. SET_M: only minute = 1. SET_S: only second = 1.
- day_wrap[i] pulses on the tick that wraps channel i. Editing never generates day_wrap.

## Timing
- Reset values:
  - All channels 00:00:00; divider 0; sel 0; FSM RUN.
  - Outputs: time_bcd 0, second/minute/hour 0, editing 0, day_wrap 0.
- Asynchronous assert clears all state immediately; release is synchronous to clk.
- First tick is asserted in cycle CLK_HZ-1 after reset release; channels update at the end of that cycle.
- Pipeline latency:
  - Channel and FSM state update on the edge that samples the input pulse or tick.
  - All outputs are registered and reflect the new state one edge later (latency 1).
  - day_wrap is registered the same way.
- Pulse inputs are assumed one cycle wide. A held level is treated as one pulse per cycle.
- rst mid-edit returns everything to reset values; no edit persists.

## Structure
- Shared package clock_pkg holds:
  - edit state enum (RUN, SET_H, SET_M, SET_S);
  - BCD digit typedef;
  - packed hms struct {h10,h1,m10,m1,s10,s1};
  - constants MAX_HOUR=23, MAX_MIN_SEC=59.
- Sub-module hms_counter: one channel, instantiated NUM_CLK times.
  - Inputs: tick_en, inc_h, inc_m, inc_s.
  - Outputs: hms, wrap.
- Divider, FSM, select logic and output mux live in multi_clock_core.

## Test plan
Simulate with CLK_HZ=4, NUM_CLK=3.
- Reset release, 4*60 cycles → every channel reads 00:01:00; second LED toggles each tick.
- Preload channel 1 to 23:59:59 via edits, return to RUN, wait one tick → channel 1 reads 00:00:00 and day_wrap=3'b010 for exactly one cycle.
- sel=0: nextP, 25 add pulses → hours 01 (wrap 23→00), no minute change. Second nextP, 61 add pulses → minutes 01. Channel 0 stays frozen over 40 cycles while channels 1 and 2 advance by 10 s.
- mode in SET_M → sel=1, editing=0, channel 0 resumes with its edited value. Three mode pulses total → sel wraps to 0.
- Same-cycle mode+nextP → sel advances, FSM stays RUN. Same-cycle nextP+add in SET_H → moves to SET_M, hours unchanged.
- Assert rst during SET_S with channel 2 at 12:34:56 → all outputs 0 immediately; after release all channels read 00:00:00.
